// File: rtl/reg_file32.sv
// 31x32 register file, r0 hardwired to zero, $sp (r29) resets to SP_RESET.
// Reads are combinational with no write bypass; writes land on the rising edge and are never stalled.
module reg_file32 #(
   parameter logic [31:0] SP_RESET = 32'h0000_3FFC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWrite,
   input  logic [4:0]  Rw,
   input  logic [31:0] busW,
   input  logic [4:0]  Ra,
   input  logic [4:0]  Rb,
   output logic [31:0] busA,
   output logic [31:0] busB,
   input  logic [4:0]  Rdbg,
   output logic [31:0] busDbg
);

   logic [31:0] regs [1:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= (i == 29) ? SP_RESET : 32'h0000_0000;
         end
      end else if (RegWrite && (Rw != 5'd0)) begin
         regs[Rw] <= busW;
      end
   end

   // Index 0 has no storage, so it is decoded before the array lookup.
   always_comb begin
      busA   = 32'h0000_0000;
      busB   = 32'h0000_0000;
      busDbg = 32'h0000_0000;
      if (Ra != 5'd0)
         busA = regs[Ra];
      if (Rb != 5'd0)
         busB = regs[Rb];
      if (Rdbg != 5'd0)
         busDbg = regs[Rdbg];
   end

endmodule

// File: tb/tb_reg_file32.sv
// Directed bench for reg_file32: vector table plus reset, r0, bypass and async-reset sequences.
module tb_reg_file32;

   logic        clk;
   logic        clk_en;
   logic        rst_n;
   logic        RegWrite;
   logic [4:0]  Rw;
   logic [31:0] busW;
   logic [4:0]  Ra;
   logic [4:0]  Rb;
   logic [31:0] busA;
   logic [31:0] busB;
   logic [4:0]  Rdbg;
   logic [31:0] busDbg;

   int n_checks;
   int n_fail;

   logic [31:0] model [0:31];

   typedef struct {
      logic        we;
      logic [4:0]  rw;
      logic [31:0] wdat;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rdbg;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] exp_dbg;
   } vec_t;

   vec_t vecs [0:7];

   reg_file32 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RegWrite (RegWrite),
      .Rw       (Rw),
      .busW     (busW),
      .Ra       (Ra),
      .Rb       (Rb),
      .busA     (busA),
      .busB     (busB),
      .Rdbg     (Rdbg),
      .busDbg   (busDbg)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      RegWrite = v.we;
      Rw       = v.rw;
      busW     = v.wdat;
      Ra       = v.ra;
      Rb       = v.rb;
      Rdbg     = v.rdbg;
      @(posedge clk);
      #1;
      if (v.we && v.rw != 5'd0)
         model[v.rw] = v.wdat;
      check($sformatf("vec%0d busA", idx), busA, v.exp_a);
      check($sformatf("vec%0d busB", idx), busB, v.exp_b);
      check($sformatf("vec%0d busDbg", idx), busDbg, v.exp_dbg);
   endtask

   task automatic sweep(input string name, input int lo);
      for (int r = lo; r < 32; r++) begin
         Rdbg = r[4:0];
         #1;
         check($sformatf("%s r%0d", name, r), busDbg, model[r]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk      = 1'b0;
      clk_en   = 1'b0;
      rst_n    = 1'b1;
      RegWrite = 1'b0;
      Rw       = 5'd0;
      busW     = 32'h0;
      Ra       = 5'd0;
      Rb       = 5'd0;
      Rdbg     = 5'd29;

      //           we    rw     wdat          ra     rb     rdbg   exp_a         exp_b         exp_dbg
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  5'd29, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00003FFC};
      vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  5'd0,  32'h00000000, 32'hDEADBEEF, 32'h00000000};
      vecs[2] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd0,  5'd7,  32'h11111111, 32'h00000000, 32'h11111111};
      vecs[3] = '{1'b0, 5'd3,  32'h12345678, 5'd3,  5'd3,  5'd3,  32'h00000000, 32'h00000000, 32'h00000000};
      vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  5'd31, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D};
      vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 5'd5,  32'h00000001, 32'hCAFEF00D, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 5'd29, 32'h87654321, 5'd29, 5'd29, 5'd29, 32'h87654321, 32'h87654321, 32'h87654321};
      vecs[7] = '{1'b0, 5'd29, 32'h00000000, 5'd29, 5'd7,  5'd29, 32'h87654321, 32'h11111111, 32'h87654321};

      // Reset pulse with the clock stopped, then sweep every index.
      #2 rst_n = 1'b0;
      #1 check("reset_async dbg29", busDbg, 32'h00003FFC);
      #2 rst_n = 1'b1;
      #1;
      for (int r = 0; r < 32; r++)
         model[r] = (r == 29) ? 32'h00003FFC : 32'h0;
      sweep("reset_sweep", 0);

      clk_en = 1'b1;
      for (int i = 0; i < 8; i++)
         apply(vecs[i], i);

      // Write to r0 must leave every register untouched.
      @(negedge clk);
      RegWrite = 1'b1;
      Rw       = 5'd0;
      busW     = 32'hFFFFFFFF;
      Ra       = 5'd0;
      @(posedge clk);
      #1;
      check("r0 busA", busA, 32'h0);
      RegWrite = 1'b0;
      sweep("r0_sweep", 1);

      // No bypass: old value before the edge, new value after.
      @(negedge clk);
      RegWrite = 1'b1;
      Rw       = 5'd7;
      busW     = 32'h22222222;
      Ra       = 5'd7;
      Rb       = 5'd7;
      #1;
      check("rdw before busA", busA, 32'h11111111);
      check("rdw before busB", busB, 32'h11111111);
      @(posedge clk);
      #1;
      check("rdw after busA", busA, 32'h22222222);
      model[7] = 32'h22222222;

      // Async reset mid-run discards a pending write.
      @(negedge clk);
      Rw   = 5'd29;
      busW = 32'hA5A5A5A5;
      Rdbg = 5'd29;
      @(posedge clk);
      #1;
      check("sp write", busDbg, 32'hA5A5A5A5);
      #2;
      Rw    = 5'd5;
      busW  = 32'h55555555;
      rst_n = 1'b0;
      #1;
      check("async reset dbg29", busDbg, 32'h00003FFC);
      Ra = 5'd5;
      Rb = 5'd7;
      @(posedge clk);
      #1;
      check("reset blocks write r5", busA, 32'h0);
      check("reset clears r7", busB, 32'h0);

      // First edge after deassertion performs the write.
      @(negedge clk);
      rst_n = 1'b1;
      Rw    = 5'd5;
      busW  = 32'h00000077;
      @(posedge clk);
      #1;
      check("post reset write r5", busA, 32'h00000077);
      check("post reset r29", busDbg, 32'h00003FFC);

      RegWrite = 1'b0;
      clk_en   = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
